cpu_mem_arbiter: RTL
====================

Name: cpu_mem_arbiter

Overview:
- Arbitrates line-fill and writeback traffic from the instruction cache and the data cache onto the single shared memory port of the core.
- Sits directly downstream of the two cache instances.
- Accepts one request at a time, issues it to memory with a valid/ready handshake, waits for the memory response, and routes it back to the requesting cache as a one-cycle response pulse.

Parameters:
- ADDR_W, 32, byte address width of requests.
- LINE_W, 128, cache line width in bits (data width of fills and writebacks).

Ports:
- clock  in  1  core clock
- reset  in  1  synchronous, active-high reset
- ic_req_valid  in  1  icache miss request valid (read only)
- ic_req_ready  out  1  icache request accepted this cycle
- ic_req_addr  in  ADDR_W  icache line address
- ic_resp_valid  out  1  one-cycle icache fill pulse
- ic_resp_data  out  LINE_W  icache fill line
- dc_req_valid  in  1  dcache request valid
- dc_req_ready  out  1  dcache request accepted this cycle
- dc_req_write  in  1  1 = writeback, 0 = fill
- dc_req_addr  in  ADDR_W  dcache line address
- dc_req_wdata  in  LINE_W  writeback line
- dc_resp_valid  out  1  one-cycle dcache fill/write-ack pulse
- dc_resp_data  out  LINE_W  dcache fill line (0 on write ack)
- mem_req_valid  out  1  memory request valid
- mem_req_ready  in  1  memory accepts request
- mem_req_write  out  1  memory write
- mem_req_addr  out  ADDR_W  memory address
- mem_req_wdata  out  LINE_W  memory write data
- mem_resp_valid  in  1  memory response/ack, one cycle
- mem_resp_data  in  LINE_W  memory read data
- proto_err  out  1  sticky: mem_resp_valid seen outside WAIT

Behaviour:
- Clock and reset: single clock. Reset is synchronous and active-high.
- Reset values: state=IDLE. All *_valid, *_ready, mem_req_write and proto_err are 0. All address and data outputs are 0. Last-grant flag = icache.
- FSM states: IDLE, ISSUE, WAIT.
- IDLE:
  - The grant is computed combinationally from ic_req_valid and dc_req_valid. Only the granted source sees *_req_ready=1, and only while in IDLE.
  - On a grant, latch owner, addr, write and wdata (icache write is forced to 0). Next state is ISSUE.
  - With no request, stay in IDLE.
- ISSUE:
  - mem_req_valid=1. mem_req_addr, mem_req_write and mem_req_wdata are driven from the latched registers and held stable until mem_req_ready=1.
  - When mem_req_valid && mem_req_ready, move to WAIT. mem_req_valid drops to 0 the next cycle.
- WAIT:
  - On mem_resp_valid, register the owner's resp_data: mem_resp_data for reads, 0 for writes.
  - Pulse the owner's resp_valid for exactly one cycle, the cycle after mem_resp_valid. Next state is IDLE.
  - The non-owner resp_valid is never asserted.
- Latency: request accepted in cycle N, mem_req_valid asserted from N+1. If memory is ready at once and responds in cycle M, resp_valid is asserted in cycle M+1.
- Back-to-back: a new request can be accepted in the cycle resp_valid is high, because the state is already IDLE. Minimum per-request occupancy is 3 cycles plus memory latency.
- Simultaneous ic and dc requests in IDLE: fixed priority, dcache wins. The icache request stays pending and is granted on the next IDLE cycle if still valid.
- mem_resp_valid in IDLE or ISSUE is ignored for routing and sets proto_err=1. proto_err clears only on reset.
- Reset mid-transaction: return to IDLE, discard latched state, assert no response pulse. A late mem_resp_valid arriving after reset sets proto_err.
- Requesters must hold valid/addr/data until ready. The arbiter samples them only in the ready cycle.

Optional Feature:
- Macro: CPU_MEM_ARB_RR_EN.
- Defined: round-robin arbitration. When both requesters are valid in IDLE, grant the source not equal to the last-grant flag. The flag updates on every grant and resets to icache, so the first simultaneous conflict goes to dcache.
- Undefined: fixed dcache priority as above, and the last-grant flag is not implemented.

Test Plan:
- Single icache fill: ic_req_valid addr=0x0000_0040; mem_req_ready=1; mem responds 3 cycles after issue with 0xDEADBEEF_...01. Required: mem_req_addr=0x40 and mem_req_write=0; ic_resp_valid one cycle with that data; dc_resp_valid stays 0.
- dcache writeback: dc_req_write=1, addr=0x1000, wdata=0xA5A5...; mem_req_ready low for 4 cycles. Required: mem_req_* stable across the stall; after the ack, dc_resp_valid pulses with dc_resp_data=0.
- Simultaneous requests, ic addr=0x20 and dc addr=0x80, both held valid:
  - Without the macro: dc is served first, then ic.
  - With CPU_MEM_ARB_RR_EN: first conflict goes to dc. Two further conflicts alternate ic then dc.
- Back-to-back: a dc request is held valid while an ic response completes. Required: dc_req_ready is asserted in the same cycle as ic_resp_valid.
- Reset mid-WAIT, then mem_resp_valid 2 cycles later. Required: no resp_valid pulse, state IDLE, proto_err=1.
- Spurious response: mem_resp_valid while IDLE with no traffic. Required: proto_err set and held, with no resp_valid on either port.

Source files
------------

// File: rtl/cpu_mem_arbiter.sv
// Shares the single memory port between the icache and dcache, one transaction at a time.
// Optional build macro CPU_MEM_ARB_RR_EN selects round-robin arbitration instead of fixed dcache priority.
module cpu_mem_arbiter #(
   parameter int ADDR_W = 32,
   parameter int LINE_W = 128
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              ic_req_valid,
   output logic              ic_req_ready,
   input  logic [ADDR_W-1:0] ic_req_addr,
   output logic              ic_resp_valid,
   output logic [LINE_W-1:0] ic_resp_data,
   input  logic              dc_req_valid,
   output logic              dc_req_ready,
   input  logic              dc_req_write,
   input  logic [ADDR_W-1:0] dc_req_addr,
   input  logic [LINE_W-1:0] dc_req_wdata,
   output logic              dc_resp_valid,
   output logic [LINE_W-1:0] dc_resp_data,
   output logic              mem_req_valid,
   input  logic              mem_req_ready,
   output logic              mem_req_write,
   output logic [ADDR_W-1:0] mem_req_addr,
   output logic [LINE_W-1:0] mem_req_wdata,
   input  logic              mem_resp_valid,
   input  logic [LINE_W-1:0] mem_resp_data,
   output logic              proto_err
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2
   } state_t;

   // Handshakes: a request transfers on the clock edge where *_req_valid and
   // *_req_ready are both high; mem_req_* likewise transfers on valid && ready.
   state_t state;
   logic   owner_dc;
   logic   pick_dc;
   logic   grant_ic;
   logic   grant_dc;

`ifdef CPU_MEM_ARB_RR_EN
   logic last_dc;
   // On a conflict, hand the port to whoever did not win last time.
   assign pick_dc = !last_dc;
`else
   assign pick_dc = 1'b1;
`endif

   always_comb begin
      grant_dc = dc_req_valid && (!ic_req_valid || pick_dc);
      grant_ic = ic_req_valid && !grant_dc;
   end

   assign ic_req_ready = (state == IDLE) && !reset && grant_ic;
   assign dc_req_ready = (state == IDLE) && !reset && grant_dc;

   always_ff @(posedge clock) begin
      if (reset) begin
         state         <= IDLE;
         owner_dc      <= 1'b0;
         mem_req_valid <= 1'b0;
         mem_req_write <= 1'b0;
         mem_req_addr  <= '0;
         mem_req_wdata <= '0;
         ic_resp_valid <= 1'b0;
         ic_resp_data  <= '0;
         dc_resp_valid <= 1'b0;
         dc_resp_data  <= '0;
         proto_err     <= 1'b0;
`ifdef CPU_MEM_ARB_RR_EN
         last_dc       <= 1'b0;
`endif
      end else begin
         ic_resp_valid <= 1'b0;
         dc_resp_valid <= 1'b0;
         if (mem_resp_valid && (state != WAIT)) begin
            proto_err <= 1'b1;
         end
         case (state)
            IDLE: begin
               if (grant_ic || grant_dc) begin
                  owner_dc      <= grant_dc;
                  mem_req_valid <= 1'b1;
                  mem_req_write <= grant_dc && dc_req_write;
                  mem_req_addr  <= grant_dc ? dc_req_addr : ic_req_addr;
                  mem_req_wdata <= grant_dc ? dc_req_wdata : '0;
                  state         <= ISSUE;
`ifdef CPU_MEM_ARB_RR_EN
                  last_dc       <= grant_dc;
`endif
               end
            end
            ISSUE: begin
               if (mem_req_ready) begin
                  mem_req_valid <= 1'b0;
                  state         <= WAIT;
               end
            end
            WAIT: begin
               if (mem_resp_valid) begin
                  // Write acks return an all-zero line to the dcache.
                  if (owner_dc) begin
                     dc_resp_valid <= 1'b1;
                     dc_resp_data  <= mem_req_write ? '0 : mem_resp_data;
                  end else begin
                     ic_resp_valid <= 1'b1;
                     ic_resp_data  <= mem_resp_data;
                  end
                  state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
